// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divider FSM states, in-flight operation record and sizing constants.
package mdu_pkg;

  localparam int unsigned MDU_DATA_WIDTH = 32;
  localparam int unsigned DIV_CNT_WIDTH  = $clog2(MDU_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } DivStatusEnum;

  // quot doubles as the dividend shift register during CALC; rem/divisor hold magnitudes.
  typedef struct packed {
    logic [MDU_DATA_WIDTH-1:0] quot;
    logic [MDU_DATA_WIDTH-1:0] rem;
    logic [MDU_DATA_WIDTH-1:0] divisor;
    logic                      dividend_neg;
    logic                      quot_neg;
    logic                      div_zero;
    logic [DIV_CNT_WIDTH-1:0]  cnt;
  } div_flow_t;

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and trial-subtract.
module div_restoring_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  quot_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  quot_bit
);

  logic [DATA_WIDTH:0] partial;
  logic [DATA_WIDTH:0] diff;

  assign partial  = {rem, quot_msb};
  assign diff     = partial - {1'b0, divisor};
  // A clear top bit means the trial subtraction did not borrow.
  assign quot_bit = ~diff[DATA_WIDTH];
  assign rem_next = quot_bit ? diff[DATA_WIDTH-1:0] : partial[DATA_WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Iterative restoring divider for div.w/mod.w/div.wu/mod.wu with valid/ready handshakes.
module divider
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  div_valid_i,
  output logic                  div_ready_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  input  logic                  div_signed_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam logic [DIV_CNT_WIDTH-1:0] LastCnt = DIV_CNT_WIDTH'(DATA_WIDTH - 1);

  DivStatusEnum state_q, state_d;
  div_flow_t    flow_q, flow_d;

  logic                  accept;
  logic                  dividend_sign;
  logic                  divisor_sign;
  logic                  divisor_zero;
  logic [DATA_WIDTH-1:0] dividend_abs;
  logic [DATA_WIDTH-1:0] divisor_abs;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_bit;

  assign dividend_sign = div_signed_i & dividend_i[DATA_WIDTH-1];
  assign divisor_sign  = div_signed_i & divisor_i[DATA_WIDTH-1];
  assign dividend_abs  = dividend_sign ? -dividend_i : dividend_i;
  assign divisor_abs   = divisor_sign ? -divisor_i : divisor_i;
  assign divisor_zero  = (divisor_i == '0);

  div_restoring_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem      (flow_q.rem),
    .quot_msb (flow_q.quot[DATA_WIDTH-1]),
    .divisor  (flow_q.divisor),
    .rem_next (step_rem),
    .quot_bit (step_bit)
  );

  assign div_ready_o = (state_q == IDLE) | ((state_q == DONE) & res_ready_i);
  assign res_valid_o = (state_q == DONE);
  assign accept      = div_valid_i & div_ready_o & ~flush_i;

  always_comb begin
    state_d = state_q;
    flow_d  = flow_q;
    case (state_q)
      CALC: begin
        flow_d.rem  = step_rem;
        flow_d.quot = {flow_q.quot[DATA_WIDTH-2:0], step_bit};
        flow_d.cnt  = flow_q.cnt + 1'b1;
        if (flow_q.cnt == LastCnt) state_d = DONE;
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      // Divide-by-zero parks |dividend| in rem so the fix-up restores the original dividend.
      flow_d.quot         = divisor_zero ? '1 : dividend_abs;
      flow_d.rem          = divisor_zero ? dividend_abs : '0;
      flow_d.divisor      = divisor_abs;
      flow_d.dividend_neg = dividend_sign;
      flow_d.quot_neg     = dividend_sign ^ divisor_sign;
      flow_d.div_zero     = divisor_zero;
      flow_d.cnt          = '0;
      state_d             = divisor_zero ? DONE : CALC;
    end

    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flow_q  <= '0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
    end
  end

  assign quotient_o  = (flow_q.quot_neg & ~flow_q.div_zero) ? -flow_q.quot : flow_q.quot;
  assign remainder_o = flow_q.dividend_neg ? -flow_q.rem : flow_q.rem;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider against a plain-arithmetic division model.
module tb_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_i = 1'b0;
  logic         div_valid_i = 1'b0;
  logic         div_ready_o;
  logic         res_valid_o;
  logic         res_ready_i = 1'b0;
  logic         div_signed_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  int errors = 0;
  int checks = 0;

  divider #(
    .DATA_WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .div_signed_i (div_signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  always #5 clk = ~clk;

  // Truncating division in 64-bit arithmetic; overflow wraps naturally on the 32-bit cut.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (b == 32'h0) begin
      q = '1;
      r = a;
      return;
    end
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    qq = sa / sb;
    rr = sa % sb;
    q  = qq[31:0];
    r  = rr[31:0];
  endfunction

  // Presents one request, scrambles inputs after accept, waits for res_valid_o (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic rdy, output int lat,
                        output logic [31:0] q, output logic [31:0] r);
    dividend_i   = a;
    divisor_i    = b;
    div_signed_i = sgn;
    div_valid_i  = 1'b1;
    #1 rdy = div_ready_o;
    @(posedge clk);
    #1;
    div_valid_i  = 1'b0;
    res_ready_i  = 1'b0;
    dividend_i   = $urandom;
    divisor_i    = $urandom;
    div_signed_i = ~sgn;
    lat = 1;
    while (!res_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient_o;
    r = remainder_o;
  endtask

  task automatic retire();
    res_ready_i = 1'b1;
    @(posedge clk);
    #1 res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    div_valid_i = 1'b1;
    dividend_i  = 32'h1234;
    divisor_i   = 32'h0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst         = 1'b0;
    div_valid_i = 1'b0;
    checks++;
    if (div_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b want=1", div_ready_o);
    end
    checks++;
    if (res_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", res_valid_o);
    end
    checks++;
    if (quotient_o !== 32'h0) begin
      errors++; $display("FAIL reset_quot got=%h want=0", quotient_o);
    end
    checks++;
    if (remainder_o !== 32'h0) begin
      errors++; $display("FAIL reset_rem got=%h want=0", remainder_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] da [8];
    logic [31:0] db [8];
    logic        ds [8];
    logic [31:0] eq [8];
    logic [31:0] er [8];
    int          el [8];
    logic [31:0] q, r;
    logic        rdy;
    int          lat;
    da = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB,
           32'h80000000};
    db = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF};
    ds = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    eq = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'h0};
    er = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'd5, 32'hFFFFFFFB, 32'h80000000};
    el = '{33, 33, 33, 33, 33, 1, 1, 33};
    for (int i = 0; i < 8; i++) begin
      run_op(da[i], db[i], ds[i], rdy, lat, q, r);
      checks++;
      if (rdy !== 1'b1) begin
        errors++; $display("FAIL directed%0d_ready got=%b want=1", i, rdy);
      end
      checks++;
      if (lat != el[i]) begin
        errors++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, el[i]);
      end
      checks++;
      if ({q, r} !== {eq[i], er[i]}) begin
        errors++;
        $display("FAIL directed%0d_result got q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, q, r, eq, er;
    logic        rdy;
    int          lat;
    a = $urandom;
    b = $urandom_range(1, 1000);
    ref_div(a, b, 1'b0, eq, er);
    run_op(a, b, 1'b0, rdy, lat, q, r);
    checks++;
    if ({q, r} !== {eq, er}) begin
      errors++; $display("FAIL bp_first got q=%h r=%h want q=%h r=%h", q, r, eq, er);
    end
    for (int i = 0; i < 10; i++) begin
      div_valid_i = 1'b1;
      dividend_i  = $urandom;
      divisor_i   = 32'h0;
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid_o, div_ready_o, quotient_o, remainder_o} !== {1'b1, 1'b0, eq, er}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h", i,
                 res_valid_o, div_ready_o, quotient_o, remainder_o, eq, er);
      end
    end
    res_ready_i = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, rdy, lat, q, r);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL bp_same_cycle_ready got=%b want=1", rdy);
    end
    checks++;
    if (lat != 33) begin
      errors++; $display("FAIL bp_latency got=%0d want=33", lat);
    end
    checks++;
    if ({q, r} !== {32'd3, 32'd0}) begin
      errors++; $display("FAIL bp_result got q=%h r=%h want q=3 r=0", q, r);
    end
    retire();
  endtask

  task automatic test_flush();
    int seen;
    // Flush beats a divide-by-zero request presented in IDLE.
    div_valid_i = 1'b1;
    dividend_i  = 32'd5;
    divisor_i   = 32'd0;
    flush_i     = 1'b1;
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    checks++;
    if ({div_ready_o, res_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle got rdy=%b v=%b want rdy=1 v=0", div_ready_o, res_valid_o);
    end
    div_valid_i  = 1'b1;
    dividend_i   = $urandom;
    divisor_i    = $urandom_range(1, 50);
    div_signed_i = 1'b0;
    @(posedge clk);
    #1 div_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i     = 1'b1;
    div_valid_i = 1'b1;
    divisor_i   = 32'd0;
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    checks++;
    if ({div_ready_o, res_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_calc got rdy=%b v=%b want rdy=1 v=0", div_ready_o, res_valid_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (res_valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL flush_discard got valid_cycles=%0d want=0", seen);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] q, r;
    logic        rdy;
    int          lat;
    div_valid_i  = 1'b1;
    dividend_i   = 32'hDEADBEEF;
    divisor_i    = 32'd13;
    div_signed_i = 1'b1;
    @(posedge clk);
    #1 div_valid_i = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({div_ready_o, res_valid_o, quotient_o, remainder_o} !== {2'b10, 64'h0}) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b v=%b q=%h r=%h want rdy=1 v=0 q=0 r=0", div_ready_o,
               res_valid_o, quotient_o, remainder_o);
    end
    run_op(32'd1, 32'd1, 1'b0, rdy, lat, q, r);
    checks++;
    if (lat != 33 || {q, r} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL rst_then_1div1 got lat=%0d q=%h r=%h want lat=33 q=1 r=0",
                         lat, q, r);
    end
    retire();
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic        sgn, rdy;
    int          lat, elat;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ref_div(a, b, sgn, eq, er);
      elat = (b == 32'h0) ? 1 : 33;
      run_op(a, b, sgn, rdy, lat, q, r);
      checks++;
      if (lat != elat || {q, r} !== {eq, er}) begin
        errors++;
        $display("FAIL rand%0d %h/%h s=%b got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h", i, a,
                 b, sgn, lat, q, r, elat, eq, er);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, q, r, eq, er;
    logic        sgn, rdy;
    int          lat, elat;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) res_ready_i = 1'b1;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      ref_div(a, b, sgn, eq, er);
      elat = (b == 32'h0) ? 1 : 33;
      run_op(a, b, sgn, rdy, lat, q, r);
      checks++;
      if (rdy !== 1'b1 || lat != elat || {q, r} !== {eq, er}) begin
        errors++;
        $display("FAIL b2b%0d %h/%h s=%b got rdy=%b lat=%0d q=%h r=%h want rdy=1 lat=%0d q=%h r=%h",
                 i, a, b, sgn, rdy, lat, q, r, elat, eq, er);
      end
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative radix-2 restoring integer divider in the MDU; the division counterpart of the pipelined Wallace-tree multiplier.
- Produces a 32-bit quotient and remainder for signed and unsigned division (div.w/mod.w/div.wu/mod.wu).
- Uses the same valid/ready handshake style as the multiplier.
- Operands are captured at accept. One operation is in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand, quotient and remainder width. The iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  abort the in-flight operation (pipeline flush).
- div_valid_i  input  1  request valid.
- div_ready_o  output  1  divider can accept a request this cycle.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  consumer accepts the result.
- div_signed_i  input  1  1 = two's-complement operands.
- dividend_i  input  DATA_WIDTH  dividend.
- divisor_i  input  DATA_WIDTH  divisor.
- quotient_o  output  DATA_WIDTH  quotient.
- remainder_o  output  DATA_WIDTH  remainder.

Behaviour:
- Reset is synchronous and active-high (rst), on clock clk.
  - After reset: state IDLE, div_ready_o=1, res_valid_o=0, quotient_o=0, remainder_o=0, iteration counter=0.
- States:
  - IDLE: accept when div_valid_i=1. Go to CALC, or to DONE if the divisor is 0.
  - CALC: one restoring step per cycle. Counter counts 0..DATA_WIDTH-1. Go to DONE after the step with counter=DATA_WIDTH-1.
  - DONE: res_valid_o=1. On res_ready_i=1, go to IDLE, or start directly if a new request is accepted that same cycle.
- div_ready_o = (state==IDLE) | (state==DONE & res_ready_i). Back-to-back operations therefore have no bubble.
- Accept cycle: latch |dividend|, |divisor|, sign of dividend, sign of quotient (sign(a)^sign(b), signed only), and a divide-by-zero flag.
  - Absolute values apply only when div_signed_i=1. Unsigned operands are latched unchanged.
- CALC step:
  - partial = {rem[DATA_WIDTH-1:0], quot_msb}. Compute diff = partial - divisor as a DATA_WIDTH+1-bit subtraction.
  - If diff is non-negative, rem = diff and the quotient bit is 1. Otherwise rem = partial and the quotient bit is 0.
  - The quotient register shifts left with the new bit.
- Latency: accept at cycle 0, res_valid_o asserted at cycle DATA_WIDTH+1 (33). Divide-by-zero: res_valid_o asserted at cycle 1.
- Sign fix-up is combinational from the DONE registers:
  - quotient is negated if the quotient-sign flag is set.
  - remainder is negated if the dividend was negative.
  - The remainder takes the sign of the dividend.
- Divide by zero, any signedness: quotient_o = all ones, remainder_o = original dividend_i.
- Signed overflow (0x80000000 / -1): quotient_o = 0x80000000, remainder_o = 0. This falls out of the algorithm with no special case, but it must be verified.
- While res_valid_o=1 and res_ready_i=0, quotient_o/remainder_o and all state are held stable.
- Inputs are ignored when div_ready_o=0, and changes to inputs after accept have no effect.
- flush_i=1 in any state:
  - Next state is IDLE and res_valid_o=0 the next cycle.
  - A request presented in the same cycle is not accepted; flush has priority over accept.
  - An in-flight result is discarded.
- rst mid-operation behaves as a flush and also clears the outputs.
- quotient_o/remainder_o outside DONE are don't-care but must be X-free.

Decomposition:
- Shared package mdu_pkg:
  - DivStatusEnum {IDLE, CALC, DONE}.
  - div_flow_t: quot, rem, divisor, dividend_neg, quot_neg, div_zero, cnt.
  - DIV_CNT_WIDTH = $clog2(DATA_WIDTH).
- One combinational sub-module, div_restoring_step: inputs rem, quot_msb, divisor; outputs next rem and quotient bit.
- The top module holds the FSM, the handshake and the sign fix-up.

Test Plan:
- Unsigned 100/7, accept at cycle 0 -> res_valid_o rises at cycle 33, quotient_o=14, remainder_o=2.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. Signed 7/-2 -> 0xFFFFFFFD, 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient_o=0x80000000, remainder_o=0. Unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF, 0.
- Unsigned 5/0 -> res_valid_o at cycle 1, quotient_o=0xFFFFFFFF, remainder_o=5. Signed -5/0 -> 0xFFFFFFFF, 0xFFFFFFFB.
- Backpressure:
  - Hold res_ready_i=0 for 10 cycles in DONE -> outputs stable and div_ready_o=0.
  - Then assert res_ready_i with a new 9/3 request -> accepted the same cycle; result 3, 0 at 33 cycles later.
- Abort:
  - flush_i pulse at CALC cycle 10 -> IDLE next cycle, div_ready_o=1, no res_valid_o.
  - rst at cycle 20 -> all outputs 0.
  - A following request 1/1 -> quotient_o=1, remainder_o=0.
